// File: rtl/i2c_pkg.sv
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    PTR,
    WRITE,
    READ,
    RACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  // Bit-counter values: 8 data bits shifted, then the 9th (ACK) slot is held.
  localparam logic [3:0] BITS_DONE = 4'd8;
  localparam logic [3:0] ACK_HELD  = 4'd9;

endpackage

// File: rtl/i2c_bus_sync.sv
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so an SCL edge never aliases as START/STOP.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned REG_COUNT   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       busy,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] host_rd_addr,
  output logic [7:0] host_rd_data
);

  localparam int unsigned IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_in),
    .sda_i     (sda_in),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  i2c_state_e state_q;
  logic [3:0] bitcnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic [7:0] ptr_q;
  logic       sda_q;
  logic       busy_q;
  logic       wr_en_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [REG_COUNT];
  logic [7:0] ptr_rd_data;

  function automatic logic in_range(input logic [7:0] idx);
    return 32'(idx) < REG_COUNT;
  endfunction

  always_comb begin
    ptr_rd_data  = 8'hFF;
    host_rd_data = 8'hFF;
    if (in_range(ptr_q))        ptr_rd_data  = regs_q[ptr_q[IDX_W-1:0]];
    if (in_range(host_rd_addr)) host_rd_data = regs_q[host_rd_addr[IDX_W-1:0]];
  end

  // Bank commits one clk after the strobe so a same-cycle host read sees the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wr_en_q) begin
      regs_q[wr_addr_q[IDX_W-1:0]] <= wr_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      rw_q      <= I2C_RW_WRITE;
      ptr_q     <= '0;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (start_det) begin
        state_q  <= ADDR;
        busy_q   <= 1'b1;
        bitcnt_q <= '0;
        sda_q    <= 1'b1;
      end else if (stop_det) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        sda_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE, WAIT_STOP: sda_q <= 1'b1;

          ADDR: begin
            if (scl_rise && bitcnt_q < BITS_DONE) begin
              shift_q  <= {shift_q[6:0], sda_s};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == BITS_DONE) begin
              rw_q     <= shift_q[0];
              bitcnt_q <= '0;
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_q   <= I2C_ACK;
                state_q <= ACK_ADDR;
              end else begin
                sda_q   <= I2C_NACK;
                state_q <= WAIT_STOP;
              end
            end
          end

          ACK_ADDR: begin
            if (scl_fall) begin
              bitcnt_q <= '0;
              if (rw_q == I2C_RW_READ) begin
                shift_q <= ptr_rd_data;
                sda_q   <= ptr_rd_data[7];
                state_q <= READ;
              end else begin
                sda_q   <= 1'b1;
                state_q <= PTR;
              end
            end
          end

          PTR, WRITE: begin
            if (scl_rise && bitcnt_q < BITS_DONE) begin
              shift_q  <= {shift_q[6:0], sda_s};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == BITS_DONE) begin
              sda_q    <= I2C_ACK;
              bitcnt_q <= ACK_HELD;
              if (state_q == PTR) begin
                ptr_q <= shift_q;
              end else begin
                if (in_range(ptr_q)) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= ptr_q;
                  wr_data_q <= shift_q;
                end
                ptr_q <= ptr_q + 8'd1;
              end
            end else if (scl_fall && bitcnt_q == ACK_HELD) begin
              sda_q    <= 1'b1;
              bitcnt_q <= '0;
              state_q  <= WRITE;
            end
          end

          READ: begin
            if (scl_fall) begin
              if (bitcnt_q == 4'd7) begin
                sda_q    <= 1'b1;
                bitcnt_q <= '0;
                state_q  <= RACK;
              end else begin
                sda_q    <= shift_q[6];
                shift_q  <= {shift_q[6:0], 1'b0};
                bitcnt_q <= bitcnt_q + 4'd1;
              end
            end
          end

          RACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) state_q <= WAIT_STOP;
              else                   ptr_q   <= ptr_q + 8'd1;
            end else if (scl_fall) begin
              shift_q  <= ptr_rd_data;
              sda_q    <= ptr_rd_data[7];
              bitcnt_q <= '0;
              state_q  <= READ;
            end
          end

          default: begin
            state_q <= IDLE;
            sda_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_out     = sda_q;
  assign busy        = busy_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (slave) responder to the team's I2C master: a single-address device with an internal byte register bank.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Supports register-pointer writes, data writes, and reads via repeated START, with pointer auto-increment.
- Sits on the board-side bus opposite the master; exposes a write-notify strobe and a host read port.

Parameters:
DEV_ADDR, 7'h50, 7-bit device address this target answers to
REG_COUNT, 16, number of implemented 8-bit registers (1..256); pointer values >= REG_COUNT are unimplemented
SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
scl_in  in  1  bus SCL as seen by target
sda_in  in  1  bus SDA as seen by target
sda_out  out  1  open-drain SDA drive: 0 = pull low, 1 = release
busy  out  1  high from detected START until detected STOP
reg_wr_en  out  1  one-clk pulse per accepted in-range data byte
reg_wr_addr  out  8  register written (valid with reg_wr_en)
reg_wr_data  out  8  byte written (valid with reg_wr_en)
host_rd_addr  in  8  host-side register index
host_rd_data  out  8  combinational register[host_rd_addr]; 8'hFF if out of range

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - sda_out=1, busy=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0.
  - All registers=0, pointer=0, state=IDLE, synchronisers=1.
- Reset mid-transfer releases SDA on the next edge; the bus transfer is abandoned.
- Inputs pass SYNC_STAGES flops plus one history flop. Events are taken on the synchronised values:
  - SCL rise/fall: edge of synchronised SCL.
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
- Required master timing: SCL high and low phases >= SYNC_STAGES+2 clk. The team master (4 clk high / 4 clk low) meets this.
- SDA sampling and driving:
  - Incoming SDA bits are sampled on SCL rise.
  - sda_out changes only on the clk after a detected SCL fall.
  - The only exceptions are reset and STOP/START, both of which force sda_out=1.
- START, from any state, including repeated START:
  - busy=1, bit counter=0, go to ADDR.
  - The pointer is kept.
- STOP, from any state: sda_out=1, busy=0, go to IDLE.
- States:
  - IDLE: sda_out=1; wait for START.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W).
    - After the 8th SCL fall: if addr==DEV_ADDR, drive 0 and go to ACK_ADDR.
    - Otherwise go to WAIT_STOP with SDA released (NACK).
  - ACK_ADDR: hold 0 through the 9th SCL pulse. On its fall:
    - R/W=0: release, go to PTR.
    - R/W=1: load shift register from register[pointer] (8'hFF if out of range), drive MSB, go to READ.
  - PTR: shift 8 bits; pointer <= byte. ACK (0) through the 9th pulse, then go to WRITE.
  - WRITE: shift 8 bits, then ACK through the 9th pulse.
    - In range: register[pointer] <= byte; reg_wr_en pulses one clk together with the update.
    - Out-of-range bytes are still ACKed but discarded, with no strobe.
    - pointer <= pointer+1, 8-bit wrap 0xFF->0x00.
    - Stay in WRITE for burst writes.
  - READ: drive shift-register bits MSB first, each changing on an SCL fall.
    - After the 8th fall: release SDA, go to RACK.
  - RACK: sample master's bit on the 9th SCL rise.
    - 0 (ACK): pointer+1 (wrap), reload, drive next MSB on the fall, go to READ.
    - 1 (NACK): go to WAIT_STOP, SDA released.
  - WAIT_STOP: SDA released; leave only on STOP (go to IDLE) or START (go to ADDR).
- Simultaneous events:
  - rst dominates START/STOP.
  - START/STOP dominate SCL edges.
  - A register write strobe and a host read of the same index in the same clk return the old value; the new value is visible the next clk.
- busy is deasserted in WAIT_STOP only by STOP.

Decomposition:
- Package i2c_pkg holds:
  - state enum: IDLE, ADDR, ACK_ADDR, PTR, WRITE, READ, RACK, WAIT_STOP.
  - Constants: I2C_RW_WRITE=0, I2C_RW_READ=1, I2C_ACK=0, I2C_NACK=1.
- One sub-module, i2c_bus_sync: synchronisers, history flop, and scl_rise / scl_fall / start_det / stop_det pulses.
- The register bank is an array in the top module.

Test Plan:
- Write, DEV_ADDR=0x50: START, 0xA0, 0x03, 0xA5, STOP -> target ACKs all 3 slots; reg_wr_en pulses once with addr 0x03 / data 0xA5; host_rd_data@0x03=0xA5; busy low after STOP.
- Read via repeated START: after the write test, START, 0xA0, 0x03, Sr, 0xA1, read 1 byte, NACK, STOP -> SDA carries 1010_0101 MSB first; SDA released in RACK; state IDLE.
- Address mismatch: START, 0xA2, 0x03, 0x11, STOP -> sda_out stays 1 for the whole frame; no reg_wr_en; registers unchanged.
- Burst write, REG_COUNT=16, pointer 0x0E: data 0x11, 0x22, 0x33 -> reg 0x0E=0x11, 0x0F=0x22; third byte ACKed, no strobe.
- Burst read from 0x0E: master ACKs then NACKs after the 3rd byte -> reads 0x11, 0x22, 0xFF.
- Disruptions:
  - STOP inserted after 4 data bits: target returns to IDLE, no write, sda_out=1.
  - rst=1 while target is driving 0 in READ: sda_out=1 next clk, busy=0, all registers 0.
